fetch_ctrl_unit: RTL and testbench

FETCH_CTRL_UNIT -- requirements
Module: fetch_ctrl_unit

---
 rtl/fetch_ctrl_unit.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_unit.sv
// Instruction-fetch stage controller: owns the PC, the IF/ID register and a
// RUN/HALT/STEP debug state machine that gates the whole pipeline.
module fetch_ctrl_unit #(
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_target_pc,
  input  logic [31:0] i_imem_data,
  input  logic        i_dbg_halt,
  input  logic        i_dbg_step,
  input  logic        i_dbg_resume,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid,
  output logic        o_pipe_en,
  output logic        o_halted,
  output logic        o_program_end,
  output logic [31:0] o_cycle_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        end_q, end_d;
  logic [31:0] cnt_q, cnt_d;
  logic        halted_q;
  logic        pipe_en_q;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN, S_STEP: begin
        cnt_d = cnt_q + 32'd1;
        // A debug halt lands after this edge; the current cycle still advances.
        if (state_q == S_STEP || i_dbg_halt) begin
          state_d = S_HALT;
        end
        if (!i_stall) begin
          if (i_flush) begin
            pc_d    = i_target_pc & ~32'd3;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            pc4_d   = 32'd0;
          end else if (i_imem_data == HALT_WORD) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            end_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = pc_plus4;
            instr_d = i_imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end
      end
      S_HALT: begin
        // Once the program has ended only reset can leave HALT.
        if (!end_q) begin
          if (i_dbg_step) begin
            state_d = S_STEP;
          end else if (i_dbg_resume) begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_RUN;
      pc_q      <= 32'd0;
      instr_q   <= NOP_WORD;
      pc4_q     <= 32'd0;
      valid_q   <= 1'b0;
      end_q     <= 1'b0;
      cnt_q     <= 32'd0;
      halted_q  <= 1'b0;
      pipe_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      end_q     <= end_d;
      cnt_q     <= cnt_d;
      halted_q  <= (state_d == S_HALT);
      pipe_en_q <= (state_d != S_HALT);
    end
  end

  assign o_imem_addr   = pc_q;
  assign o_ifid_instr  = instr_q;
  assign o_ifid_pc4    = pc4_q;
  assign o_ifid_valid  = valid_q;
  assign o_pipe_en     = pipe_en_q;
  assign o_halted      = halted_q;
  assign o_program_end = end_q;
  assign o_cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Bench for fetch_ctrl_unit: a transaction-level model compared every cycle,
// plus literal expectations at the interesting points of a directed script.
module tb_fetch_ctrl_unit;

  localparam logic [31:0] HALT_W = 32'hFFFFFFFF;
  localparam logic [31:0] NOP_W  = 32'h00000000;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic        clk;
  logic        rst;
  logic        stall, flush, dbg_halt, dbg_step, dbg_resume;
  logic [31:0] target_pc;
  logic [31:0] imem_data, imem_addr;
  logic [31:0] ifid_instr, ifid_pc4, cycle_cnt;
  logic        ifid_valid, pipe_en, halted, program_end;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl_unit #(.HALT_WORD(HALT_W), .NOP_WORD(NOP_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_target_pc(target_pc), .i_imem_data(imem_data),
    .i_dbg_halt(dbg_halt), .i_dbg_step(dbg_step), .i_dbg_resume(dbg_resume),
    .o_imem_addr(imem_addr), .o_ifid_instr(ifid_instr), .o_ifid_pc4(ifid_pc4),
    .o_ifid_valid(ifid_valid), .o_pipe_en(pipe_en), .o_halted(halted),
    .o_program_end(program_end), .o_cycle_cnt(cycle_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a few fixed words, otherwise an address-derived pattern.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h20010005;
      32'h0000_001C: return HALT_W;
      32'h0000_0100: return HALT_W;
      default:       return 32'h13000000 ^ a;
    endcase
  endfunction

  assign imem_data = imem_word(imem_addr);

  // Behavioural model of what the fetch stage must look like after each edge
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    int          mode;
    logic        pend;
    logic [31:0] cnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pc = 0; r.instr = NOP_W; r.pc4 = 0; r.valid = 0;
    r.mode = M_RUN; r.pend = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t s, logic st, logic fl, logic [31:0] tg,
                                        logic dh, logic ds, logic dr);
    model_t n;
    logic [31:0] w;
    n = s;
    if (s.mode == M_HALT) begin
      if (!s.pend) begin
        if (ds) n.mode = M_STEP;
        else if (dr) n.mode = M_RUN;
      end
      return n;
    end
    n.cnt  = s.cnt + 1;
    n.mode = (s.mode == M_STEP || dh) ? M_HALT : M_RUN;
    w = imem_word(s.pc);
    if (st) return n;
    if (fl) begin
      n.pc = {tg[31:2], 2'b00}; n.instr = NOP_W; n.valid = 0; n.pc4 = 0;
      return n;
    end
    if (w == HALT_W) begin
      n.instr = NOP_W; n.valid = 0; n.pend = 1; n.mode = M_HALT;
      return n;
    end
    n.pc4 = s.pc + 32'd4; n.pc = s.pc + 32'd4; n.instr = w; n.valid = 1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m, stall, flush, target_pc, dbg_halt, dbg_step, dbg_resume);
  end

  // Scoreboard helpers
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, once reset has been applied
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check32("m_pc", imem_addr, m.pc);
      check32("m_instr", ifid_instr, m.instr);
      check32("m_pc4", ifid_pc4, m.pc4);
      check1("m_valid", ifid_valid, m.valid);
      check1("m_pipe_en", pipe_en, m.mode != M_HALT);
      check1("m_halted", halted, m.mode == M_HALT);
      check1("m_end", program_end, m.pend);
      check32("m_cnt", cycle_cnt, m.cnt);
    end
  end

  // Driver: present inputs for one rising edge, then return them to idle
  task automatic cyc(input logic s, input logic f, input logic [31:0] t,
                     input logic h, input logic st, input logic r);
    stall = s; flush = f; target_pc = t; dbg_halt = h; dbg_step = st; dbg_resume = r;
    @(posedge clk);
    #1;
    stall = 0; flush = 0; target_pc = 0; dbg_halt = 0; dbg_step = 0; dbg_resume = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check32({tag, "_pc"}, imem_addr, 32'h0);
    check32({tag, "_instr"}, ifid_instr, NOP_W);
    check32({tag, "_pc4"}, ifid_pc4, 32'h0);
    check1({tag, "_valid"}, ifid_valid, 1'b0);
    check1({tag, "_halted"}, halted, 1'b0);
    check1({tag, "_pipe_en"}, pipe_en, 1'b1);
    check1({tag, "_end"}, program_end, 1'b0);
    check32({tag, "_cnt"}, cycle_cnt, 32'h0);
  endtask

  typedef struct {
    logic        s, f, h, r;
    logic [31:0] t;
  } vec_t;

  vec_t tbl [10];

  initial begin
    stall = 0; flush = 0; target_pc = 0; dbg_halt = 0; dbg_step = 0; dbg_resume = 0;
    rst = 0;
    #1 rst = 1;
    cmp_en = 1'b1;
    #10;
    check_reset_values("rst0");
    @(posedge clk); #1 rst = 0;

    // Sequential fetch from address 0
    idle();
    check32("seq_instr", ifid_instr, 32'h20010005);
    check32("seq_pc4", ifid_pc4, 32'h4);
    check1("seq_valid", ifid_valid, 1'b1);
    check32("seq_pc", imem_addr, 32'h4);
    idle();
    check32("seq_pc8", imem_addr, 32'h8);

    // Stall beats a simultaneous flush; flush applies when re-presented
    cyc(1, 1, 32'h40, 0, 0, 0);
    check32("stfl_pc", imem_addr, 32'h8);
    check32("stfl_instr", ifid_instr, 32'h13000004);
    check32("stfl_pc4", ifid_pc4, 32'h8);
    cyc(0, 1, 32'h40, 0, 0, 0);
    check32("fl_pc", imem_addr, 32'h40);
    check32("fl_instr", ifid_instr, NOP_W);
    check1("fl_valid", ifid_valid, 1'b0);
    check32("fl_pc4", ifid_pc4, 32'h0);
    cyc(0, 1, 32'h43, 0, 0, 0);
    check32("misalign_pc", imem_addr, 32'h40);

    // Step/resume in RUN are ignored; bring cycle count to 10
    cyc(0, 0, 32'h0, 0, 1, 1);
    repeat (4) idle();
    check32("cnt10", cycle_cnt, 32'd10);
    check32("pc54", imem_addr, 32'h54);

    // Debug halt, then step (with resume, step wins), then resume
    cyc(0, 0, 32'h0, 1, 0, 0);
    check1("dh_halted", halted, 1'b1);
    check32("dh_cnt", cycle_cnt, 32'd11);
    check32("dh_pc", imem_addr, 32'h58);
    repeat (3) idle();
    check32("frozen_cnt", cycle_cnt, 32'd11);
    check32("frozen_pc", imem_addr, 32'h58);
    cyc(0, 0, 32'h0, 0, 1, 1);
    check1("step_halted", halted, 1'b0);
    check1("step_pipe_en", pipe_en, 1'b1);
    idle();
    check32("step_pc", imem_addr, 32'h5C);
    check32("step_cnt", cycle_cnt, 32'd12);
    check1("step_rehalt", halted, 1'b1);
    check32("step_instr", ifid_instr, 32'h13000058);
    cyc(0, 0, 32'h0, 0, 0, 1);
    check1("resume_halted", halted, 1'b0);
    check32("resume_cnt", cycle_cnt, 32'd12);

    // Halt word at 0x1C: program ends, debug requests ignored
    cyc(0, 1, 32'h1C, 0, 0, 0);
    idle();
    check32("hw_pc", imem_addr, 32'h1C);
    check1("hw_end", program_end, 1'b1);
    check1("hw_halted", halted, 1'b1);
    check32("hw_instr", ifid_instr, NOP_W);
    cyc(0, 0, 32'h0, 0, 0, 1);
    cyc(0, 0, 32'h0, 0, 1, 0);
    idle();
    check1("hw_resume_ignored", halted, 1'b1);
    check32("hw_pc_hold", imem_addr, 32'h1C);

    // Asynchronous reset from HALT, checked before the next edge
    #2 rst = 1;
    #1;
    check_reset_values("arst_halt");
    @(posedge clk); #1 rst = 0;

    // PC wrap
    cyc(0, 1, 32'hFFFFFFFE, 0, 0, 0);
    check32("wrap_pre_pc", imem_addr, 32'hFFFFFFFC);
    idle();
    check32("wrap_pc", imem_addr, 32'h0);
    check32("wrap_pc4", ifid_pc4, 32'h0);
    check32("wrap_instr", ifid_instr, 32'hECFFFFFC);

    // Halt word fetched during STEP
    cyc(0, 1, 32'h100, 1, 0, 0);
    check32("sh_pc", imem_addr, 32'h100);
    check1("sh_halted", halted, 1'b1);
    cyc(0, 0, 32'h0, 0, 1, 0);
    idle();
    check1("sh_end", program_end, 1'b1);
    check1("sh_halted2", halted, 1'b1);
    check32("sh_pc2", imem_addr, 32'h100);
    cyc(0, 0, 32'h0, 0, 1, 0);
    idle();
    check1("sh_step_ignored", halted, 1'b1);

    // Reset while in STEP
    #2 rst = 1;
    @(posedge clk); #1 rst = 0;
    cyc(0, 0, 32'h0, 1, 0, 0);
    cyc(0, 0, 32'h0, 0, 1, 0);
    check1("instep_halted", halted, 1'b0);
    #2 rst = 1;
    #1;
    check_reset_values("arst_step");
    @(posedge clk); #1 rst = 0;

    // Directed mix checked by the model
    tbl[0] = '{s: 0, f: 0, h: 0, r: 0, t: 32'h0};
    tbl[1] = '{s: 1, f: 0, h: 0, r: 0, t: 32'h0};
    tbl[2] = '{s: 0, f: 1, h: 0, r: 0, t: 32'h200};
    tbl[3] = '{s: 0, f: 0, h: 0, r: 0, t: 32'h0};
    tbl[4] = '{s: 1, f: 1, h: 0, r: 0, t: 32'h300};
    tbl[5] = '{s: 0, f: 1, h: 0, r: 0, t: 32'h305};
    tbl[6] = '{s: 1, f: 0, h: 1, r: 0, t: 32'h0};
    tbl[7] = '{s: 0, f: 0, h: 0, r: 1, t: 32'h0};
    tbl[8] = '{s: 0, f: 0, h: 0, r: 0, t: 32'h0};
    tbl[9] = '{s: 0, f: 1, h: 1, r: 0, t: 32'h50};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].s, tbl[i].f, tbl[i].t, tbl[i].h, 0, tbl[i].r);
    end
    check32("tbl_pc", imem_addr, 32'h50);
    check1("tbl_halted", halted, 1'b1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
